// File: rtl/fetch_prefetch_unit.sv
// Fetch stage with a DEPTH-entry prefetch FIFO.
// Issues one read per cycle to a synchronous-read instruction memory while
// credit allows. Each returned word is buffered together with its PC and PC+4.
// Decode drains the FIFO through IF_VALID/IF_READY. A redirect discards every
// word that has been fetched but not yet consumed.
module fetch_prefetch_unit #(
    parameter int          XLEN      = 32,
    parameter int          ADDR_BITS = 14,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic                       REDIRECT,
    input  logic [XLEN-1:0]            REDIRECT_PC,
    output logic [ADDR_BITS-1:0]       IMEM_ADDR,
    output logic                       IMEM_RDEN,
    input  logic [XLEN-1:0]            IMEM_RDATA,
    output logic                       IF_VALID,
    input  logic                       IF_READY,
    output logic [XLEN-1:0]            IF_IR,
    output logic [XLEN-1:0]            IF_PC,
    output logic [XLEN-1:0]            IF_PC_4,
    output logic [$clog2(DEPTH):0]     IF_LEVEL
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    // Request stage (p0): PC and the in-flight tag.
    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] tag_p0;
    logic            vld_p0;

    // FIFO storage (p1): response words with their PCs.
    logic [XLEN-1:0] fifo_ir  [DEPTH];
    logic [XLEN-1:0] fifo_pc  [DEPTH];
    logic [XLEN-1:0] fifo_pc4 [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   count;

    // Last head shown to decode; presented while the FIFO is empty.
    logic [XLEN-1:0] last_ir;
    logic [XLEN-1:0] last_pc;
    logic [XLEN-1:0] last_pc4;

    logic issue;
    logic push;
    logic pop;
    logic head_vld;
    logic unused_bits;

    // The low two target bits are forced to zero, so they are never read.
    assign unused_bits = ^REDIRECT_PC[1:0];

    // Issue, push and pop decisions for this cycle.
    always_comb begin
        issue    = 1'b0;
        push     = 1'b0;
        head_vld = (count != '0);
        pop      = head_vld && IF_READY;
        // Pre-pop occupancy plus the outstanding request must leave room.
        if (!RESET && !REDIRECT && ((count + LW'(vld_p0)) < LW'(DEPTH))) begin
            issue = 1'b1;
        end
        // A redirect in the response cycle kills the returning word.
        if (vld_p0 && !REDIRECT) begin
            push = 1'b1;
        end
    end

    assign IMEM_RDEN = issue;
    assign IMEM_ADDR = pc_p0[ADDR_BITS+1:2];
    assign IF_VALID  = head_vld;
    assign IF_LEVEL  = count;
    assign IF_IR     = head_vld ? fifo_ir[rd_ptr]  : last_ir;
    assign IF_PC     = head_vld ? fifo_pc[rd_ptr]  : last_pc;
    assign IF_PC_4   = head_vld ? fifo_pc4[rd_ptr] : last_pc4;

    // Control state: PC, in-flight flag, FIFO pointers and occupancy.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pc_p0  <= XLEN'(RESET_PC);
            vld_p0 <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (REDIRECT) begin
            pc_p0  <= {REDIRECT_PC[XLEN-1:2], 2'b00};
            vld_p0 <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            vld_p0 <= issue;
            if (issue) begin
                pc_p0 <= pc_p0 + XLEN'(4);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + LW'(1);
            end else if (!push && pop) begin
                count <= count - LW'(1);
            end
        end
    end

    // Request tag: the PC of the word currently on its way back.
    always_ff @(posedge CLOCK) begin
        if (issue) begin
            tag_p0 <= pc_p0;
        end
    end

    // FIFO tail write of the returning word with its PC and PC+4.
    always_ff @(posedge CLOCK) begin
        if (push && !RESET) begin
            fifo_ir[wr_ptr]  <= IMEM_RDATA;
            fifo_pc[wr_ptr]  <= tag_p0;
            fifo_pc4[wr_ptr] <= tag_p0 + XLEN'(4);
        end
    end

    // Hold the most recent head so outputs stay put once the FIFO drains.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            last_ir  <= '0;
            last_pc  <= '0;
            last_pc4 <= '0;
        end else if (head_vld) begin
            last_ir  <= fifo_ir[rd_ptr];
            last_pc  <= fifo_pc[rd_ptr];
            last_pc4 <= fifo_pc4[rd_ptr];
        end
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parameterised successor to the single-entry fetch stage. It generates the PC and issues instruction reads to a synchronous-read instruction memory. Returned words are buffered with their PC and PC+4 in a DEPTH-entry prefetch FIFO. Decode drains the FIFO through a valid/ready handshake, and a redirect from execute (branch/JAL/JALR) flushes all fetched-but-unconsumed state.

Parameters:
XLEN, 32, instruction/PC width
ADDR_BITS, 14, word-address width to instruction memory (address = PC[ADDR_BITS+1:2])
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned

Ports:
CLOCK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-high reset
REDIRECT  in  1  taken branch/jump this cycle
REDIRECT_PC  in  XLEN  target PC; bits [1:0] ignored (treated as 0)
IMEM_ADDR  out  ADDR_BITS  word address of the current request
IMEM_RDEN  out  1  read request, combinational
IMEM_RDATA  in  XLEN  read data, valid the cycle after the request
IF_VALID  out  1  FIFO head holds a valid instruction
IF_READY  in  1  decode accepts the head this cycle
IF_IR  out  XLEN  head instruction
IF_PC  out  XLEN  head PC
IF_PC_4  out  XLEN  head PC+4
IF_LEVEL  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset is synchronous and active-high on RESET; clock is CLOCK.
- Reset values:
  - PC = RESET_PC; FIFO emptied; in-flight flag = 0.
  - IF_VALID = 0; IF_LEVEL = 0; IF_IR/IF_PC/IF_PC_4 = 0.
  - IMEM_RDEN = 0 while RESET is high.
- Request issue:
  - IMEM_RDEN = !RESET && !REDIRECT && (occupancy + inflight < DEPTH). Occupancy is pre-pop, so the credit check is conservative.
  - IMEM_ADDR = PC[ADDR_BITS+1:2].
  - On an issued request: PC <= PC + 4 (mod 2^XLEN), inflight <= 1, and the request PC is latched into the tag register.
  - With no request and no redirect, inflight <= 0.
- Response capture:
  - In the cycle after an issued request, if no kill applies, {IMEM_RDATA, tag, tag+4} is written at the FIFO tail on the rising edge.
  - Credit accounting guarantees the write never overflows.
- Latency: with the first cycle after RESET low being cycle 0:
  - request in cycle 0;
  - data on IMEM_RDATA in cycle 1, written at the end of cycle 1;
  - IF_VALID = 1 in cycle 2.
  - Steady state with IF_READY held high: one instruction per cycle.
- Handshake:
  - Pop occurs when IF_VALID && IF_READY.
  - IF_IR/IF_PC/IF_PC_4 are stable while IF_VALID=1 and IF_READY=0.
  - IF_READY is ignored when IF_VALID=0.
- Full/empty:
  - Full → no request.
  - Empty → IF_VALID=0, outputs are don't-care (held at last value).
  - Simultaneous push and pop → occupancy unchanged.
  - Read/write pointers wrap modulo DEPTH.
- Redirect, cycle n:
  - FIFO flushed (occupancy 0, IF_VALID=0 from cycle n+1).
  - PC <= {REDIRECT_PC[XLEN-1:2], 2'b00}.
  - No request in cycle n.
  - Any response arriving in cycle n+1 from a cycle-n-1 request is dropped (inflight cleared).
  - First request to the target issues in cycle n+1; target valid in cycle n+3.
  - A pop in the same cycle n is still performed; redirect takes priority over push.
- Priority: RESET > REDIRECT > normal operation. RESET during a redirect or with a request in flight discards everything.
- PC+4 wraps at 2^XLEN without a flag.

Test Plan:
1. Reset release, RESET_PC=0, IF_READY=1, IMEM word n = n*0x11 → IF_VALID rises cycle 2 with IF_PC=0, IF_PC_4=4, IF_IR=0; then consecutive PCs 4, 8, 12 each cycle.
2. IF_READY=0 after release → exactly 4 requests (PC 0, 4, 8, 12); IF_LEVEL=4; IMEM_RDEN=0 thereafter; head held at PC 0. Raise IF_READY → PCs 0, 4, 8, 12, 16 delivered in order, no gap after the first.
3. Steady streaming, REDIRECT=1 with REDIRECT_PC=0x100 in cycle n → IF_VALID=0 in n+1 and n+2; IF_PC=0x100 in n+3; the in-flight word is never delivered.
4. REDIRECT_PC=0x203 → delivered IF_PC=0x200, IMEM_ADDR=0x80.
5. FIFO full with IF_READY toggling 1/0 every cycle → no lost or duplicated PCs; IF_LEVEL never exceeds 4.
6. RESET asserted while inflight=1 with FIFO level 2 → next cycle IF_VALID=0 and IF_LEVEL=0; the returning word is dropped; the stream restarts at RESET_PC.
